apb_dual_master_ctrl: RTL and testbench

- Sequencing APB master for the 8-bit peripheral bus. It arbitrates between two local requesters (m0, m1) and runs the IDLE/SETUP/ACCESS protocol towards two slaves.
- It decodes the address to select the slave, muxes PREADY/PRDATA back, and returns completion and read data to the owning requester.
- Sits between the CPU/DMA-side request logic and the APB slaves (slave1, slave2).

---
 rtl/apb_dual_master_ctrl_pkg.sv | 17 +
 rtl/apb_dual_master_ctrl_arb.sv | 26 ++
 rtl/apb_dual_master_ctrl.sv | 167 ++++++++++++++++
 tb/tb_apb_dual_master_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_dual_master_ctrl_pkg.sv
// Shared state encoding and id constants for apb_dual_master_ctrl.
// Optional feature macro used by the controller: APB_TIMEOUT_EN.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  localparam logic SLV_1 = 1'b0;
  localparam logic SLV_2 = 1'b1;

endpackage

// File: rtl/apb_dual_master_ctrl_arb.sv
// Two-way round-robin arbiter: the requester that was not granted last wins a tie.
module apb_rr_arbiter
  import apb_ctrl_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last,
  input  logic       i_en,
  output logic [1:0] o_grant
);

  // One-hot grant, only while the controller can accept a new request
  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      case (i_valid)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = (i_last == REQ_M1) ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end else begin
      o_grant = 2'b00;
    end
  end

endmodule

// File: rtl/apb_dual_master_ctrl.sv
// Dual-requester APB master: arbitrates m0/m1, runs SETUP/ACCESS towards two slaves.
// Define APB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYCLES with err=1.
module apb_dual_master_ctrl
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int SEL_BIT = 7
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              m0_valid,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_valid,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PWRITE,
  output logic              PENABLE,
  output logic              PSEL1,
  output logic              PSEL2,
  input  logic              PREADY1,
  input  logic              PREADY2,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2
);

  apb_state_e        r_state, w_next_state;
  logic              r_last, r_owner;
  logic [1:0]        w_valid, w_grant, r_done, r_err;
  logic              w_arb_en, w_sel_ready, w_complete, w_timeout, w_req_write;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_req_wdata, w_sel_rdata, w_done_rdata, r_rdata0, r_rdata1;

  // Only the selected slave's handshake is observed
  assign w_valid     = {m1_valid, m0_valid};
  assign w_sel_ready = PSEL2 ? PREADY2 : PREADY1;
  assign w_sel_rdata = PSEL2 ? PRDATA2 : PRDATA1;
  assign w_complete  = (r_state == ST_ACCESS) && (w_sel_ready || w_timeout);
  assign w_arb_en    = (r_state == ST_IDLE) || w_complete;

  apb_rr_arbiter u_arb (
    .i_valid (w_valid),
    .i_last  (r_last),
    .i_en    (w_arb_en),
    .o_grant (w_grant)
  );

  assign m0_ack      = w_grant[0];
  assign m1_ack      = w_grant[1];
  assign w_req_write = w_grant[1] ? m1_write : m0_write;
  assign w_req_addr  = w_grant[1] ? m1_addr  : m0_addr;
  assign w_req_wdata = w_grant[1] ? m1_wdata : m0_wdata;
  assign w_done_rdata = (PWRITE || w_timeout) ? {DATA_W{1'b0}} : w_sel_rdata;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] r_tmo_cnt;

  // Counts ACCESS cycles that end without PREADY
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tmo_cnt <= {CNT_W{1'b0}};
    end else if (r_state == ST_SETUP) begin
      r_tmo_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == ST_ACCESS) && !w_sel_ready) begin
      r_tmo_cnt <= r_tmo_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign w_timeout = (r_state == ST_ACCESS) && !w_sel_ready &&
                     (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Next state: a completing ACCESS hands straight to SETUP when a new grant exists
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   w_next_state = (|w_grant) ? ST_SETUP : ST_IDLE;
      ST_SETUP:  w_next_state = ST_ACCESS;
      ST_ACCESS: begin
        if (w_complete) w_next_state = (|w_grant) ? ST_SETUP : ST_IDLE;
        else            w_next_state = ST_ACCESS;
      end
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // APB request registers, loaded on grant and held through wait states
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR   <= {ADDR_W{1'b0}};
      PWDATA  <= {DATA_W{1'b0}};
      PWRITE  <= 1'b0;
      PENABLE <= 1'b0;
      PSEL1   <= 1'b0;
      PSEL2   <= 1'b0;
      r_owner <= REQ_M0;
      r_last  <= REQ_M1;
    end else if (|w_grant) begin
      PADDR   <= w_req_addr;
      PWRITE  <= w_req_write;
      PWDATA  <= w_req_write ? w_req_wdata : {DATA_W{1'b0}};
      PSEL1   <= (w_req_addr[SEL_BIT] == SLV_1);
      PSEL2   <= (w_req_addr[SEL_BIT] == SLV_2);
      PENABLE <= 1'b0;
      r_owner <= w_grant[1];
      r_last  <= w_grant[1];
    end else if (r_state == ST_SETUP) begin
      PENABLE <= 1'b1;
    end else if (w_complete) begin
      PSEL1   <= 1'b0;
      PSEL2   <= 1'b0;
      PENABLE <= 1'b0;
    end
  end

  // Completion pulse, error flag and read data for the owning requester only
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_done   <= 2'b00;
      r_err    <= 2'b00;
      r_rdata0 <= {DATA_W{1'b0}};
      r_rdata1 <= {DATA_W{1'b0}};
    end else if (w_complete) begin
      r_done <= (r_owner == REQ_M1) ? 2'b10 : 2'b01;
      r_err  <= (r_owner == REQ_M1) ? {w_timeout, 1'b0} : {1'b0, w_timeout};
      if (r_owner == REQ_M1) r_rdata1 <= w_done_rdata;
      else                   r_rdata0 <= w_done_rdata;
    end else begin
      r_done <= 2'b00;
      r_err  <= 2'b00;
    end
  end

  assign m0_done  = r_done[0];
  assign m1_done  = r_done[1];
  assign m0_err   = r_err[0];
  assign m1_err   = r_err[1];
  assign m0_rdata = r_rdata0;
  assign m1_rdata = r_rdata1;

endmodule

// File: tb/tb_apb_dual_master_ctrl.sv
// Scoreboard bench for apb_dual_master_ctrl: random requesters, an APB slave model
// and a completion monitor, all checked against a transaction-level reference.
module tb_apb_dual_master_ctrl;

`ifdef APB_TIMEOUT_EN
  localparam int TMO_LIMIT = 16;
`else
  localparam int TMO_LIMIT = 0;
`endif

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b1;
  logic [1:0] m_valid, m_write;
  logic [7:0] m_addr [2];
  logic [7:0] m_wdata[2];
  logic       m0_ack, m1_ack, m0_done, m1_done, m0_err, m1_err;
  logic [7:0] m0_rdata, m1_rdata, PADDR, PWDATA, PRDATA1, PRDATA2;
  logic       PWRITE, PENABLE, PSEL1, PSEL2, PREADY1, PREADY2;

  typedef struct {
    bit wr; logic [7:0] addr; logic [7:0] wdata; logic [7:0] rdata; int waits; int gap;
  } req_t;
  typedef struct {
    bit owner; bit wr; logic [7:0] addr; logic [7:0] wdata; logic [7:0] rdata;
    int acc; int ack_cyc; bit tmo;
  } xfer_t;

  req_t  req_q[2][$];
  req_t  cur_req[2];
  xfer_t bus_q[$];
  xfer_t done_q[2][$];

  int checks = 0, failures = 0, cyc = 0;
  int bus_free = 0;
  int gap_left[2];
  bit acked[2];
  bit model_last = 1'b1;
  logic [7:0] last_rd[2];
  xfer_t scur;
  bit    scur_v = 1'b0;
  int    wait_left = 0;

  apb_dual_master_ctrl dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .m0_valid(m_valid[0]), .m0_write(m_write[0]), .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]),
    .m0_ack(m0_ack), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m_valid[1]), .m1_write(m_write[1]), .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]),
    .m1_ack(m1_ack), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PREADY1(PREADY1), .PREADY2(PREADY2),
    .PRDATA1(PRDATA1), .PRDATA2(PRDATA2)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_req(input int k, input bit wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] rdata,
                          input int waits, input int gap);
    req_t r;
    r.wr = wr; r.addr = addr; r.wdata = wdata; r.rdata = rdata; r.waits = waits; r.gap = gap;
    req_q[k].push_back(r);
  endtask

  // Requesters plus arbitration/acceptance-time reference
  initial begin
    xfer_t x;
    logic [1:0] ackv;
    bit w, exp_w;
    m_valid = 2'b00; m_write = 2'b00;
    for (int k = 0; k < 2; k++) begin
      m_addr[k] = 8'h00; m_wdata[k] = 8'h00; gap_left[k] = 0; acked[k] = 1'b0; last_rd[k] = 8'h00;
    end
    forever begin
      @(negedge PCLK);
      if (PRESETn) begin
        for (int k = 0; k < 2; k++) begin
          if (acked[k]) begin m_valid[k] = 1'b0; acked[k] = 1'b0; end
          if (!m_valid[k] && req_q[k].size() > 0) begin
            if (gap_left[k] > 0) gap_left[k]--;
            else begin
              cur_req[k] = req_q[k].pop_front();
              m_write[k] = cur_req[k].wr; m_addr[k] = cur_req[k].addr;
              m_wdata[k] = cur_req[k].wdata; m_valid[k] = 1'b1;
            end
          end
        end
        #1;
        ackv = {m1_ack, m0_ack};
        if (m_valid != 2'b00) begin
          exp_w = (m_valid == 2'b11) ? !model_last : m_valid[1];
          if (cyc >= bus_free) chk("grant", ackv, exp_w ? 2'b10 : 2'b01);
          else                 chk("ack_while_busy", ackv, 2'b00);
        end else begin
          chk("ack_no_valid", ackv, 2'b00);
        end
        if ((ackv == 2'b01 || ackv == 2'b10) && (ackv & m_valid) != 2'b00) begin
          w = ackv[1];
          x.owner = w; x.wr = cur_req[w].wr; x.addr = cur_req[w].addr;
          x.wdata = cur_req[w].wdata; x.rdata = cur_req[w].rdata; x.ack_cyc = cyc;
          x.tmo = (TMO_LIMIT > 0) && (cur_req[w].waits >= TMO_LIMIT);
          x.acc = x.tmo ? TMO_LIMIT : cur_req[w].waits + 1;
          bus_free = cyc + 1 + x.acc;
          model_last = w;
          acked[w] = 1'b1;
          gap_left[w] = (req_q[w].size() > 0) ? req_q[w][0].gap : 0;
          bus_q.push_back(x);
          done_q[w].push_back(x);
        end
      end
    end
  end

  // APB slave model: checks the bus phase by phase and answers after the planned waits
  initial begin
    int waits_of_item;
    PREADY1 = 1'b0; PREADY2 = 1'b0; PRDATA1 = 8'h00; PRDATA2 = 8'h00;
    forever begin
      @(negedge PCLK);
      PREADY1 = 1'($urandom); PREADY2 = 1'($urandom);
      PRDATA1 = 8'($urandom); PRDATA2 = 8'($urandom);
      if (PRESETn && (PSEL1 || PSEL2)) begin
        chk("psel_onehot", {31'b0, PSEL1 & PSEL2}, 32'd0);
        if (!PENABLE && bus_q.size() == 0) begin
          chk("setup_without_request", {31'b0, PSEL1 | PSEL2}, 32'd0);
          scur_v = 1'b0;
        end else if (!PENABLE) begin
          scur = bus_q.pop_front();
          scur_v = 1'b1;
          waits_of_item = scur.tmo ? 1000 : scur.acc - 1;
          wait_left = waits_of_item;
        end
        if (scur_v) begin
          chk("paddr", PADDR, scur.addr);
          chk("pwrite", PWRITE, scur.wr);
          chk("pwdata", PWDATA, scur.wr ? scur.wdata : 8'h00);
          chk("psel2_decode", PSEL2, scur.addr[7]);
          if (PENABLE) begin
            if (wait_left == 0) begin
              if (PSEL2) begin PREADY2 = 1'b1; PRDATA2 = scur.rdata; end
              else       begin PREADY1 = 1'b1; PRDATA1 = scur.rdata; end
            end else begin
              wait_left--;
              if (PSEL2) PREADY2 = 1'b0;
              else       PREADY1 = 1'b0;
            end
          end
        end
      end else if (PRESETn) begin
        chk("penable_without_psel", PENABLE, 1'b0);
      end
    end
  end

  // Completion monitor: pops the owner's expected result whenever done pulses
  initial begin
    xfer_t x;
    logic [1:0] dv, ev;
    logic [7:0] rd, exp_rd;
    forever begin
      @(negedge PCLK);
      dv = {m1_done, m0_done};
      ev = {m1_err, m0_err};
      chk("done_both", {31'b0, &dv}, 32'd0);
      for (int k = 0; k < 2; k++) begin
        rd = (k == 0) ? m0_rdata : m1_rdata;
        if (dv[k] && done_q[k].size() == 0) begin
          chk("unexpected_done", {31'b0, dv[k]}, 32'd0);
        end else if (dv[k]) begin
          x = done_q[k].pop_front();
          exp_rd = (x.wr || x.tmo) ? 8'h00 : x.rdata;
          chk("rdata", rd, exp_rd);
          chk("err", ev[k], x.tmo);
          chk("done_latency", cyc, x.ack_cyc + 2 + x.acc);
          last_rd[k] = exp_rd;
        end else begin
          chk("rdata_hold", rd, last_rd[k]);
          chk("err_idle", ev[k], 1'b0);
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge PCLK); #3;
      ok = (req_q[0].size() == 0) && (req_q[1].size() == 0) && (m_valid == 2'b00) &&
           !acked[0] && !acked[1] && (bus_q.size() == 0) &&
           (done_q[0].size() == 0) && (done_q[1].size() == 0);
    end
    chk("drain_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_penable();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge PCLK); #3;
      seen = PENABLE;
    end
    chk("penable_timeout", {31'b0, seen}, 32'd1);
  endtask

  task automatic check_bus_zero(input string tag);
    chk({tag, "_psel1"}, PSEL1, 1'b0);
    chk({tag, "_psel2"}, PSEL2, 1'b0);
    chk({tag, "_penable"}, PENABLE, 1'b0);
    chk({tag, "_pwrite"}, PWRITE, 1'b0);
    chk({tag, "_paddr"}, PADDR, 8'h00);
    chk({tag, "_pwdata"}, PWDATA, 8'h00);
    chk({tag, "_done"}, {m1_done, m0_done}, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge PCLK); #2;
    PRESETn = 1'b0;
    #1;
    check_bus_zero("async_reset");
    for (int k = 0; k < 2; k++) begin
      req_q[k].delete(); done_q[k].delete();
      acked[k] = 1'b0; gap_left[k] = 0; last_rd[k] = 8'h00;
    end
    bus_q.delete();
    m_valid = 2'b00;
    scur_v = 1'b0;
    model_last = 1'b1;
    repeat (2) @(negedge PCLK);
    #2;
    PRESETn = 1'b1;
    bus_free = cyc;
  endtask

  initial begin
    int k;
    #1 PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    #1;
    check_bus_zero("reset");
    chk("reset_rdata0", m0_rdata, 8'h00);
    chk("reset_rdata1", m1_rdata, 8'h00);
    @(negedge PCLK); #2;
    PRESETn = 1'b1;
    bus_free = cyc;

    push_req(0, 1'b1, 8'h01, 8'hAA, 8'h5C, 0, 0);
    wait_drain(50);
    push_req(1, 1'b0, 8'h84, 8'h00, 8'h33, 0, 0);
    wait_drain(50);
    for (int i = 0; i < 4; i++) begin
      push_req(0, 1'b0, 8'($urandom), 8'h00, 8'($urandom), 0, 0);
      push_req(1, 1'b0, 8'($urandom), 8'h00, 8'($urandom), 0, 0);
    end
    wait_drain(100);
    push_req(0, 1'b1, 8'h03, 8'hFF, 8'h00, 3, 0);
    wait_drain(50);
    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(1, 0));
      push_req(k, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               int'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
    end
    wait_drain(2000);

    push_req(1, 1'b0, 8'h82, 8'h00, 8'h5A, 1000, 0);
    wait_penable();
`ifdef APB_TIMEOUT_EN
    wait_drain(60);
    chk("timeout_psel2_drop", PSEL2, 1'b0);
    chk("timeout_penable_drop", PENABLE, 1'b0);
`else
    repeat (100) @(negedge PCLK);
    #3;
    chk("stuck_penable_held", PENABLE, 1'b1);
    chk("stuck_psel2_held", PSEL2, 1'b1);
    do_reset();
`endif

    push_req(0, 1'b1, 8'h10, 8'h77, 8'h00, 10, 0);
    wait_penable();
    repeat (3) @(negedge PCLK);
    do_reset();
    push_req(0, 1'b0, 8'h05, 8'h00, 8'hC3, 0, 0);
    push_req(1, 1'b0, 8'h85, 8'h00, 8'h3C, 0, 0);
    wait_drain(50);
    repeat (3) @(negedge PCLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
